// File: rtl/box_bounce_ctrl_if.sv
// box_bounce_ctrl_if: board-input and VGA plot-port signals of the box animation sequencer
interface box_bounce_ctrl_if;
  logic [2:0] iColour;
  logic       iEnable;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oFrame;
  logic       oBusy;
  modport master (input iColour, iEnable, output oX, oY, oColour, oPlot, oFrame, oBusy);
  modport slave  (output iColour, iEnable, input oX, oY, oColour, oPlot, oFrame, oBusy);
endinterface

// File: rtl/box_bounce_ctrl.sv
// box_bounce_ctrl: clears the screen, then erases/moves/redraws a bouncing 4x4 box on frame ticks
module box_bounce_ctrl #(
  parameter int X_SCREEN_PIXELS  = 160,
  parameter int Y_SCREEN_PIXELS  = 120,
  parameter int CLOCKS_PER_FRAME = 833333,
  parameter int FRAMES_PER_MOVE  = 15
) (
  input logic iClock,
  input logic iResetn,
  box_bounce_ctrl_if.master bus
);
  localparam int FW = CLOCKS_PER_FRAME > 1 ? $clog2(CLOCKS_PER_FRAME) : 1;
  localparam int MW = $clog2(FRAMES_PER_MOVE + 1);
  localparam logic [7:0] XL = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0] YL = 7'(Y_SCREEN_PIXELS - 1);
  localparam logic [7:0] XE = 8'(X_SCREEN_PIXELS - 4);
  localparam logic [6:0] YE = 7'(Y_SCREEN_PIXELS - 4);
  localparam logic [FW-1:0] FL = FW'(CLOCKS_PER_FRAME - 1);
  localparam logic [MW-1:0] MS = MW'(FRAMES_PER_MOVE);
  typedef enum logic [2:0] {CLEAR, DRAW, WAIT, ERASE, MOVE} state_t;
  state_t state, nxt;
  logic [FW-1:0] fc, fc_n;
  logic [MW-1:0] mc;
  logic [7:0] cx, bx;
  logic [6:0] cy, by;
  logic [3:0] k;
  logic [2:0] col;
  logic dx, dy, ndx, ndy, go, sweep;
  always_comb begin
    nxt = state;
    go = mc == MS && bus.iEnable;
    fc_n = fc == FL ? '0 : fc + 1'b1;
    // a direction flips before stepping when the box already touches its edge
    ndx = (dx && bx == XE) || (!dx && bx == 8'd0) ? ~dx : dx;
    ndy = (dy && by == YE) || (!dy && by == 7'd0) ? ~dy : dy;
    sweep = state == CLEAR || state == DRAW || state == ERASE;
    nxt = state == CLEAR ? (cx == XL && cy == YL ? DRAW : CLEAR) :
          state == DRAW  ? (k == 4'd15 ? WAIT : DRAW) :
          state == ERASE ? (k == 4'd15 ? MOVE : ERASE) :
          state == MOVE  ? DRAW :
          (go ? ERASE : WAIT);
  end
  always_ff @(posedge iClock)
    state <= !iResetn ? CLEAR : nxt;
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      fc <= '0;
      mc <= '0;
      cx <= '0;
      cy <= '0;
      k <= '0;
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
      col <= '0;
      bus.oX <= '0;
      bus.oY <= '0;
      bus.oColour <= '0;
      bus.oPlot <= 1'b0;
      bus.oFrame <= 1'b0;
      bus.oBusy <= 1'b0;
    end else begin
      fc <= fc_n;
      bus.oFrame <= fc_n == FL;
      mc <= state == WAIT && go ? '0 : bus.oFrame && mc != MS ? mc + 1'b1 : mc;
      bus.oBusy <= state != WAIT;
      bus.oPlot <= sweep;
      if (state == CLEAR) begin
        bus.oX <= cx;
        bus.oY <= cy;
        bus.oColour <= '0;
        cx <= cx == XL ? '0 : cx + 1'b1;
        cy <= cx != XL ? cy : cy == YL ? '0 : cy + 1'b1;
      end
      if (state == DRAW || state == ERASE) begin
        bus.oX <= bx + 8'(k[1:0]);
        bus.oY <= by + 7'(k[3:2]);
        bus.oColour <= state == DRAW ? col : 3'd0;
        k <= k + 1'b1;
      end
      if (state == MOVE) begin
        dx <= ndx;
        dy <= ndy;
        bx <= ndx ? bx + 1'b1 : bx - 1'b1;
        by <= ndy ? by + 1'b1 : by - 1'b1;
      end
      if (nxt == DRAW && state != DRAW)
        col <= bus.iColour;
    end
  end
endmodule

// File: tb/tb_box_bounce_ctrl.sv
// tb_box_bounce_ctrl: randomized-colour scenarios checked against a bouncing-box position model
module tb_box_bounce_ctrl;
  localparam int CPF = 4;
  localparam int FPM = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn1 = 1'b0, rstn2 = 1'b0, sel = 1'b0, en = 1'b1;
  logic [2:0] colour = 3'd0;
  box_bounce_ctrl_if b1 ();
  box_bounce_ctrl_if b2 ();
  assign b1.iColour = colour;
  assign b1.iEnable = en;
  assign b2.iColour = colour;
  assign b2.iEnable = en;
  box_bounce_ctrl #(.X_SCREEN_PIXELS(160), .Y_SCREEN_PIXELS(120), .CLOCKS_PER_FRAME(CPF), .FRAMES_PER_MOVE(FPM))
    u1 (.iClock(clk), .iResetn(rstn1), .bus(b1));
  box_bounce_ctrl #(.X_SCREEN_PIXELS(12), .Y_SCREEN_PIXELS(12), .CLOCKS_PER_FRAME(CPF), .FRAMES_PER_MOVE(FPM))
    u2 (.iClock(clk), .iResetn(rstn2), .bus(b2));
  logic [7:0] ob_x;
  logic [6:0] ob_y;
  logic [2:0] ob_col;
  logic ob_plot, ob_frame, ob_busy;
  assign ob_x = sel ? b2.oX : b1.oX;
  assign ob_y = sel ? b2.oY : b1.oY;
  assign ob_col = sel ? b2.oColour : b1.oColour;
  assign ob_plot = sel ? b2.oPlot : b1.oPlot;
  assign ob_frame = sel ? b2.oFrame : b1.oFrame;
  assign ob_busy = sel ? b2.oBusy : b1.oBusy;
  int tests = 0, fails = 0;
  int mx, my, mdx, mdy, xmax, ymax, max_bx;
  function automatic void model_reset(input int xm, input int ym);
    mx = 0; my = 0; mdx = 1; mdy = 1; xmax = xm; ymax = ym;
  endfunction
  function automatic void model_step();
    if ((mdx > 0 && mx == xmax) || (mdx < 0 && mx == 0)) mdx = -mdx;
    if ((mdy > 0 && my == ymax) || (mdy < 0 && my == 0)) mdy = -mdy;
    mx += mdx;
    my += mdy;
  endfunction
  task automatic capture(input int bx, input int by, input int c, input bit skip, input bit chg,
                         output int err, output int x0, output int y0);
    err = 0; x0 = -1; y0 = -1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0 || !skip) @(negedge clk);
      if (k == 0) begin x0 = int'(ob_x); y0 = int'(ob_y); end
      if (!(ob_plot === 1'b1 && ob_x === 8'(bx + k % 4) && ob_y === 7'(by + k / 4) && ob_col === 3'(c))) err++;
      if (k == 0 && chg) colour = colour ^ 3'($urandom_range(1, 7));
    end
  endtask
  task automatic run_move(input string nm, output int lat, output int x0, output int y0);
    int err, c, ex, ey;
    colour = 3'($urandom);
    c = int'(colour);
    lat = 0; x0 = -1; y0 = -1;
    @(negedge clk);
    while (ob_plot !== 1'b1 && lat < 100) begin lat++; @(negedge clk); end
    tests++;
    if (ob_plot !== 1'b1) begin
      fails++;
      $display("FAIL %s erase start: oPlot=%b after %0d cycles, required 1", nm, ob_plot, lat);
      return;
    end
    capture(mx, my, 0, 1'b1, 1'b0, err, ex, ey);
    tests++;
    if (err !== 0) begin fails++; $display("FAIL %s erase: %0d bad pixels, required 0 at (%0d,%0d)", nm, err, mx, my); end
    @(negedge clk);
    tests++;
    if (ob_plot !== 1'b0 || ob_busy !== 1'b1) begin
      fails++; $display("FAIL %s move cycle: plot=%b busy=%b, required 0 1", nm, ob_plot, ob_busy);
    end
    model_step();
    capture(mx, my, c, 1'b0, 1'b1, err, x0, y0);
    tests++;
    if (err !== 0) begin fails++; $display("FAIL %s draw: %0d bad pixels, required 0 at (%0d,%0d) col %0d", nm, err, mx, my, c); end
    if (!sel && x0 > max_bx) max_bx = x0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({ob_x, ob_y, ob_col} !== 18'd0) begin fails++; $display("FAIL reset coords: x=%0d y=%0d c=%0d, required 0", ob_x, ob_y, ob_col); end
    tests++;
    if ({ob_plot, ob_frame, ob_busy} !== 3'b000) begin fails++; $display("FAIL reset strobes: plot/frame/busy=%b%b%b, required 000", ob_plot, ob_frame, ob_busy); end
  endtask
  task automatic test_clear();
    int err = 0;
    colour = 3'b101; en = 1'b1; rstn1 = 1'b1;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      if (!(ob_plot === 1'b1 && ob_x === 8'(i % 160) && ob_y === 7'(i / 160) && ob_col === 3'd0 && ob_busy === 1'b1)) err++;
    end
    tests++;
    if (err !== 0) begin fails++; $display("FAIL clear sweep: %0d bad pixels, required 0", err); end
  endtask
  task automatic test_first_draw();
    int err, x0, y0;
    capture(0, 0, 5, 1'b0, 1'b1, err, x0, y0);
    tests++;
    if (err !== 0) begin fails++; $display("FAIL first draw: %0d bad pixels, required 0", err); end
    @(negedge clk);
    tests++;
    if (ob_plot !== 1'b0 || ob_busy !== 1'b0) begin fails++; $display("FAIL busy fall: plot=%b busy=%b, required 0 0", ob_plot, ob_busy); end
  endtask
  task automatic test_move();
    int lat, x0, y0;
    run_move("move1", lat, x0, y0);
    tests++;
    if (x0 !== 1 || y0 !== 1) begin fails++; $display("FAIL move1 position: (%0d,%0d), required (1,1)", x0, y0); end
  endtask
  task automatic test_right_bounce();
    int lat, x0, y0, guard = 0;
    while (!(mx == 156 && mdx == 1) && guard < 400) begin run_move("walk", lat, x0, y0); guard++; end
    run_move("bounce", lat, x0, y0);
    tests++;
    if (x0 !== 155 || mdx !== -1) begin fails++; $display("FAIL right bounce: x=%0d dx=%0d, required 155 -1", x0, mdx); end
    tests++;
    if (max_bx > 156) begin fails++; $display("FAIL bx range: max %0d, required <=156", max_bx); end
  endtask
  task automatic test_enable_low();
    int plots = 0, busy = 0, frames = 0, lat, x0, y0;
    en = 1'b0;
    for (int i = 0; i < 20 * CPF; i++) begin
      @(negedge clk);
      plots += int'(ob_plot);
      busy += int'(ob_busy);
      frames += int'(ob_frame);
    end
    tests++;
    if (plots !== 0 || busy !== 0) begin fails++; $display("FAIL enable low: plots=%0d busy=%0d, required 0 0", plots, busy); end
    tests++;
    if (frames !== 20) begin fails++; $display("FAIL frame ticks: %0d in 20 frames, required 20", frames); end
    en = 1'b1;
    run_move("resume", lat, x0, y0);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL resume latency: %0d idle cycles, required 1", lat); end
  endtask
  task automatic test_mid_clear_reset();
    int err = 0;
    rstn1 = 1'b0;
    @(negedge clk);
    rstn1 = 1'b1;
    repeat (501) @(negedge clk);
    tests++;
    if (ob_plot !== 1'b1 || ob_x !== 8'd20 || ob_y !== 7'd3) begin fails++; $display("FAIL pixel 500: plot=%b (%0d,%0d), required 1 (20,3)", ob_plot, ob_x, ob_y); end
    rstn1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({ob_x, ob_y, ob_col, ob_plot, ob_frame, ob_busy} !== 21'd0) begin
      fails++; $display("FAIL mid reset: x=%0d y=%0d c=%0d p=%b f=%b b=%b, required all 0", ob_x, ob_y, ob_col, ob_plot, ob_frame, ob_busy);
    end
    rstn1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!(ob_plot === 1'b1 && ob_x === 8'(i % 160) && ob_y === 7'(i / 160) && ob_col === 3'd0)) err++;
    end
    tests++;
    if (err !== 0) begin fails++; $display("FAIL clear restart: %0d bad pixels, required 0", err); end
  endtask
  task automatic test_corner();
    int err = 0, c, lat, x0, y0, guard = 0;
    sel = 1'b1;
    model_reset(8, 8);
    colour = 3'($urandom);
    c = int'(colour);
    rstn2 = 1'b1;
    for (int i = 0; i < 144; i++) begin
      @(negedge clk);
      if (!(ob_plot === 1'b1 && ob_x === 8'(i % 12) && ob_y === 7'(i / 12) && ob_col === 3'd0)) err++;
    end
    tests++;
    if (err !== 0) begin fails++; $display("FAIL small clear: %0d bad pixels, required 0", err); end
    capture(0, 0, c, 1'b0, 1'b1, err, x0, y0);
    tests++;
    if (err !== 0) begin fails++; $display("FAIL small first draw: %0d bad pixels, required 0", err); end
    while (!(mx == 8 && my == 8) && guard < 20) begin run_move("corner walk", lat, x0, y0); guard++; end
    run_move("corner", lat, x0, y0);
    tests++;
    if (x0 !== 7 || y0 !== 7) begin fails++; $display("FAIL corner bounce: (%0d,%0d), required (7,7)", x0, y0); end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  initial begin
    max_bx = 0;
    model_reset(156, 116);
    test_reset();
    test_clear();
    test_first_draw();
    test_move();
    test_right_bounce();
    test_enable_low();
    test_mid_clear_reset();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/box_bounce_ctrl.md
# box_bounce_ctrl

Animation sequencer that owns the VGA pixel-write port and drives a 4x4 box across the 160x120 screen. It clears the frame after reset, then repeatedly erases the box, advances its position with edge bounce, and redraws it, paced by an internal frame tick. It sits between the board inputs (colour switches, run enable) and the VGA adapter's plot interface, replacing manual load/plot sequencing.

## Interface
- X_SCREEN_PIXELS, 160: screen width in pixels.
- Y_SCREEN_PIXELS, 120: screen height in pixels.
- CLOCKS_PER_FRAME, 833333: clocks per frame tick (50 MHz / 60 Hz).
- FRAMES_PER_MOVE, 15: frame ticks between box moves.
- iClock  in  1  system clock; single clock domain.
- iResetn  in  1  reset; synchronous, active-low.
- iColour  in  3  box colour, sampled at DRAW entry.
- iEnable  in  1  run enable; low holds the box in WAIT.
- oX  out  8  pixel x coordinate.
- oY  out  7  pixel y coordinate.
- oColour  out  3  pixel colour.
- oPlot  out  1  pixel write strobe; one pixel per high cycle.
- oFrame  out  1  one-cycle frame-tick pulse.
- oBusy  out  1  high in CLEAR, ERASE, MOVE and DRAW.

## Operation
- States: CLEAR, DRAW, WAIT, ERASE, MOVE.
- Reset (iResetn=0 at an edge, including mid-sweep):
  - All outputs go to 0.
  - State goes to CLEAR; all counters are zeroed.
  - Box position is (bx,by)=(0,0); direction is dx=+1, dy=+1.
- CLEAR:
  - Plots colour 0 row-major: x 0..159 inner, y 0..119 outer, 19200 pixels.
  - After the last pixel, goes to DRAW.
- DRAW and ERASE:
  - 16 pixels, k=0..15: x=bx+k[1:0], y=by+k[3:2].
  - DRAW uses the latched colour. ERASE uses colour 0.
  - DRAW then goes to WAIT. ERASE then goes to MOVE.
- Colour latch: iColour is latched on the cycle the FSM enters DRAW.
- MOVE: one cycle, oPlot=0, then DRAW.
  - If dx=+1 and bx=156, or dx=-1 and bx=0, dx is flipped first.
  - bx then steps by the new dx.
  - The same rule applies to y, with edge values 116 and 0.
  - A corner flips both directions in the same cycle.
  - Invariant: bx stays in 0..156 and by stays in 0..116.
- Frame counter:
  - Free-running 0..CLOCKS_PER_FRAME-1 in every state.
  - oFrame=1 in the cycle the counter equals CLOCKS_PER_FRAME-1.
- Move counter:
  - Increments on oFrame in any state and saturates at FRAMES_PER_MOVE.
  - Cleared on the WAIT→ERASE transition.
- WAIT → ERASE: taken when move counter = FRAMES_PER_MOVE and iEnable=1.
  - If iEnable=0, WAIT holds indefinitely with the counter saturated.
  - When iEnable returns to 1, ERASE starts on the next edge.
- Widths: coordinates are unsigned. The sweep x counter is 8 bits and y is 7 bits; the draw counter is 4 bits.

## Timing
- All outputs are registered.
- Pixel i of a CLEAR, DRAW or ERASE sweep is presented on the (i+1)-th edge after state entry.
- oPlot is high on exactly the edges that present pixels: 19200 per CLEAR, 16 per DRAW or ERASE.
- oPlot=0 in WAIT and MOVE. oColour, oX and oY hold their last value there.
- Release timing: the first edge with iResetn=1 presents CLEAR pixel (0,0).
  - CLEAR occupies release edges 1..19200.
  - The first box pixel (0,0) in the latched colour appears on edge 19201.
  - oBusy falls on edge 19217.
- Move cycle length: ERASE 16, then MOVE 1, then DRAW 16 = 33 cycles of oBusy=1.
- Move period: at least FRAMES_PER_MOVE·CLOCKS_PER_FRAME cycles while iEnable=1.
- oFrame period is exactly CLOCKS_PER_FRAME and is unaffected by the FSM.

## Test plan
- Use CLOCKS_PER_FRAME=4 and FRAMES_PER_MOVE=2 unless stated.
- Reset, then release:
  - Expect 19200 oPlot pulses with colour 0 covering (0,0)..(159,119).
  - Then expect 16 pulses at (0..3,0..3) with iColour=3'b101.
- One move: expect 16 colour-0 pulses at (0..3,0..3), one idle cycle, then 16 pulses at (1..4,1..4).
- Right-edge bounce:
  - Run until bx=156, dx=+1.
  - Expect the next draw at bx=155 and dx=-1.
  - Check that bx never exceeds 156.
- Corner (156,116): both directions flip; the next draw is at (155,115).
- iEnable low:
  - Hold iEnable=0 for 20 frames and expect no oPlot in WAIT.
  - Raise iEnable and expect ERASE to begin on the next edge.
- Reset mid-CLEAR: assert iResetn=0 at pixel 500.
  - Next edge: oPlot=0 and outputs 0.
  - After release, CLEAR restarts at (0,0).
